// File: rtl/csr_stream_encoder_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | csr_stream_encoder_if : pixel input, value and pointer streams     |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
interface csr_stream_encoder_if #(
   parameter int WORD_LENGTH        = 8,
   parameter int DOUBLE_WORD_LENGTH = 16,
   parameter int COL_LENGTH         = 8
);
   logic                          in_valid;
   logic                          in_ready;
   logic [WORD_LENGTH-1:0]        data_in;
   logic [WORD_LENGTH-1:0]        threshold;
   logic                          val_valid;
   logic                          val_ready;
   logic [WORD_LENGTH-1:0]        val_data;
   logic [COL_LENGTH-1:0]         val_col;
   logic                          ptr_valid;
   logic                          ptr_ready;
   logic [DOUBLE_WORD_LENGTH-1:0] ptr_data;
   logic                          frame_done;
   logic [DOUBLE_WORD_LENGTH-1:0] nnz_count;

   // master: pixel producer and stream consumers; slave: the encoder
   modport master (
      output in_valid, data_in, threshold, val_ready, ptr_ready,
      input  in_ready, val_valid, val_data, val_col, ptr_valid, ptr_data,
             frame_done, nnz_count
   );

   modport slave (
      input  in_valid, data_in, threshold, val_ready, ptr_ready,
      output in_ready, val_valid, val_data, val_col, ptr_valid, ptr_data,
             frame_done, nnz_count
   );
endinterface
`default_nettype wire

// File: rtl/csr_stream_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | csr_stream_encoder : raster pixels -> CSR value and row-ptr streams |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module csr_stream_encoder_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             i_push,
   input  wire logic [WIDTH-1:0] i_push_data,
   input  wire logic             i_pop,
   output logic      [WIDTH-1:0] o_head,
   output logic                  o_valid,
   output logic                  o_full
);
   localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_aw-1:0]  r_wr;
   logic [c_aw-1:0]  r_rd;
   logic [c_aw:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & o_valid;
   assign o_head  = r_mem[r_rd];
   assign o_valid = (r_count != '0);
   assign o_full  = (r_count == (c_aw+1)'(DEPTH));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= i_push_data;
            r_wr        <= r_wr + 1'b1;
         end
         if (w_pop) begin
            r_rd <= r_rd + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

module csr_stream_encoder #(
   parameter int WORD_LENGTH        = 8,
   parameter int DOUBLE_WORD_LENGTH = 16,
   parameter int COL_LENGTH         = 8,
   parameter int IMAGE_WIDTH        = 28,
   parameter int IMAGE_HEIGHT       = 28,
   parameter int FIFO_DEPTH         = 4
) (
   input wire logic            clk,
   input wire logic            rst,
   csr_stream_encoder_if.slave bus
);
   localparam int c_row_w = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

   localparam logic [1:0] c_st_start = 2'd0;
   localparam logic [1:0] c_st_run   = 2'd1;
   localparam logic [1:0] c_st_done  = 2'd2;

   logic [1:0]                    r_state;
   logic [COL_LENGTH-1:0]         r_col;
   logic [c_row_w-1:0]            r_row;
   logic [DOUBLE_WORD_LENGTH-1:0] r_cnt;
   logic                          r_frame_done;
   logic [DOUBLE_WORD_LENGTH-1:0] r_nnz_count;

   logic                          w_val_full;
   logic                          w_ptr_full;
   logic                          w_in_ready;
   logic                          w_accept;
   logic                          w_nonzero;
   logic                          w_row_end;
   logic                          w_last;
   logic [DOUBLE_WORD_LENGTH-1:0] w_cnt_next;
   logic                          w_val_push;
   logic                          w_ptr_push;
   logic [DOUBLE_WORD_LENGTH-1:0] w_ptr_din;
   logic [WORD_LENGTH+COL_LENGTH-1:0] w_val_head;

   // Full flags are registered, so in_ready never depends on a same-cycle pop
   assign w_in_ready = (r_state == c_st_run) & ~w_val_full & ~w_ptr_full;
   assign w_accept   = bus.in_valid & w_in_ready;
   assign w_nonzero  = (bus.data_in > bus.threshold);
   assign w_cnt_next = r_cnt + DOUBLE_WORD_LENGTH'(w_nonzero);
   assign w_row_end  = (r_col == COL_LENGTH'(IMAGE_WIDTH - 1));
   assign w_last     = w_row_end & (r_row == c_row_w'(IMAGE_HEIGHT - 1));
   assign w_val_push = w_accept & w_nonzero;
   assign w_ptr_push = ((r_state == c_st_start) & ~w_ptr_full) | (w_accept & w_row_end);
   assign w_ptr_din  = (r_state == c_st_start) ? '0 : w_cnt_next;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= c_st_start;
         r_col        <= '0;
         r_row        <= '0;
         r_cnt        <= '0;
         r_frame_done <= 1'b0;
         r_nnz_count  <= '0;
      end else begin
         r_frame_done <= 1'b0;
         case (r_state)
            c_st_start: begin
               if (!w_ptr_full) begin
                  r_state <= c_st_run;
               end
            end
            c_st_run: begin
               if (w_accept) begin
                  r_cnt <= w_cnt_next;
                  if (w_row_end) begin
                     r_col <= '0;
                     r_row <= r_row + 1'b1;
                  end else begin
                     r_col <= r_col + 1'b1;
                  end
                  // frame_done and nnz_count land together on the DONE entry edge
                  if (w_last) begin
                     r_state      <= c_st_done;
                     r_frame_done <= 1'b1;
                     r_nnz_count  <= w_cnt_next;
                  end
               end
            end
            c_st_done: begin
               r_cnt   <= '0;
               r_row   <= '0;
               r_col   <= '0;
               r_state <= c_st_start;
            end
            default: r_state <= c_st_start;
         endcase
      end
   end

   csr_stream_encoder_fifo #(
      .WIDTH (WORD_LENGTH + COL_LENGTH),
      .DEPTH (FIFO_DEPTH)
   ) u_val_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_val_push),
      .i_push_data ({bus.data_in, r_col}),
      .i_pop       (bus.val_ready),
      .o_head      (w_val_head),
      .o_valid     (bus.val_valid),
      .o_full      (w_val_full)
   );

   csr_stream_encoder_fifo #(
      .WIDTH (DOUBLE_WORD_LENGTH),
      .DEPTH (FIFO_DEPTH)
   ) u_ptr_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_ptr_push),
      .i_push_data (w_ptr_din),
      .i_pop       (bus.ptr_ready),
      .o_head      (bus.ptr_data),
      .o_valid     (bus.ptr_valid),
      .o_full      (w_ptr_full)
   );

   assign bus.in_ready   = w_in_ready;
   assign bus.val_data   = w_val_head[WORD_LENGTH+COL_LENGTH-1:COL_LENGTH];
   assign bus.val_col    = w_val_head[COL_LENGTH-1:0];
   assign bus.frame_done = r_frame_done;
   assign bus.nnz_count  = r_nnz_count;
endmodule
`default_nettype wire
